// File: rtl/pwm_multi_apb.sv
// pwm_multi_apb: APB3 slave driving NUM_CH independent PWM channels.
// Each channel has shadow period/duty registers that move into the active
// registers only at a period boundary, or continuously while the channel is
// disabled, so an update never produces a truncated or stretched pulse.
// Optional feature macro: PWM_IRQ_EN adds the global STATUS/MASK page (0xF)
// and a registered level interrupt; without it the page reads 0 and irq is 0.
module pwm_multi_apb #(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 32,
    parameter int DEF_PERIOD = 1000000,
    parameter int DEF_DUTY   = 75000
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [31:0]       PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              irq
);

    localparam logic [CNT_W-1:0] DEF_PER_V  = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] DEF_DUTY_V = CNT_W'(DEF_DUTY);
    localparam logic [CNT_W-1:0] ONE_V      = CNT_W'(1);

    logic [3:0]       ch_idx;
    logic [1:0]       reg_idx;
    logic             ch_valid;
    logic             glob_page;
    logic             acc_phase;
    logic             wr_acc;
    logic [CNT_W-1:0] wdata;
    logic             unused_bits;

    logic [CNT_W-1:0] cnt    [NUM_CH];
    logic [CNT_W-1:0] per_a  [NUM_CH];
    logic [CNT_W-1:0] duty_a [NUM_CH];
    logic [CNT_W-1:0] per_s  [NUM_CH];
    logic [CNT_W-1:0] duty_s [NUM_CH];
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] inv;
    logic [NUM_CH-1:0] bnd;
    logic [31:0]       rdata;

    assign ch_idx      = PADDR[11:8];
    assign reg_idx     = PADDR[3:2];
    assign ch_valid    = ({1'b0, ch_idx} < 5'(NUM_CH));
    assign glob_page   = (ch_idx == 4'hF);
    assign acc_phase   = PSEL & PENABLE;
    assign wr_acc      = acc_phase & PWRITE;
    assign wdata       = PWDATA[CNT_W-1:0];
    assign unused_bits = ^{PADDR[31:12], PADDR[7:4], PADDR[1:0], PWDATA};

    assign PREADY  = 1'b1;
    assign PSLVERR = acc_phase & ~ch_valid & ~glob_page;
    assign PRDATA  = rdata;

    // Boundary flags: the last count of a running period, where shadows commit
    always_comb begin
        bnd = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            bnd[i] = en[i] && (per_a[i] > ONE_V) && (cnt[i] == per_a[i] - ONE_V);
        end
    end

    // Per-channel counters, active/shadow registers, control bits and outputs
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]    <= '0;
                per_a[i]  <= DEF_PER_V;
                duty_a[i] <= DEF_DUTY_V;
                per_s[i]  <= DEF_PER_V;
                duty_s[i] <= DEF_DUTY_V;
            end
            en      <= '1;
            inv     <= '0;
            pwm_out <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                pwm_out[i] <= (en[i] & (cnt[i] < duty_a[i])) ^ inv[i];
                if (!en[i]) begin
                    cnt[i]    <= '0;
                    per_a[i]  <= per_s[i];
                    duty_a[i] <= duty_s[i];
                end else if (per_a[i] <= ONE_V) begin
                    cnt[i] <= '0;
                end else if (bnd[i]) begin
                    cnt[i]    <= '0;
                    per_a[i]  <= per_s[i];
                    duty_a[i] <= duty_s[i];
                end else begin
                    cnt[i] <= cnt[i] + ONE_V;
                end
                if (wr_acc && ch_valid && (ch_idx == 4'(i))) begin
                    case (reg_idx)
                        2'd0: duty_s[i] <= wdata;
                        2'd1: per_s[i]  <= wdata;
                        2'd2: begin
                            en[i]  <= PWDATA[0];
                            inv[i] <= PWDATA[1];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef PWM_IRQ_EN
    logic [NUM_CH-1:0] status;
    logic [NUM_CH-1:0] mask;
    logic [NUM_CH-1:0] status_nxt;
    logic [NUM_CH-1:0] mask_nxt;
    logic [NUM_CH-1:0] clr;
    logic              irq_q;

    // Next STATUS/MASK: write-1-to-clear, with a boundary set winning over a clear
    always_comb begin
        clr      = '0;
        mask_nxt = mask;
        if (wr_acc && glob_page && (reg_idx == 2'd0)) begin
            clr = PWDATA[NUM_CH-1:0];
        end
        if (wr_acc && glob_page && (reg_idx == 2'd1)) begin
            mask_nxt = PWDATA[NUM_CH-1:0];
        end
        status_nxt = (status & ~clr) | bnd;
    end

    // Sticky status, mask and the registered interrupt level
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            status <= '0;
            mask   <= '0;
            irq_q  <= 1'b0;
        end else begin
            status <= status_nxt;
            mask   <= mask_nxt;
            irq_q  <= |(status_nxt & mask_nxt);
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    // Read mux: shadow values for DUTY/PERIOD, zero-filled above CNT_W
    always_comb begin
        rdata = '0;
        if (PSEL && ch_valid) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_idx == 4'(i)) begin
                    case (reg_idx)
                        2'd0:    rdata = 32'(duty_s[i]);
                        2'd1:    rdata = 32'(per_s[i]);
                        2'd2:    rdata = {30'b0, inv[i], en[i]};
                        default: rdata = 32'(cnt[i]);
                    endcase
                end
            end
        end
`ifdef PWM_IRQ_EN
        else if (PSEL && glob_page) begin
            case (reg_idx)
                2'd0:    rdata = 32'(status);
                2'd1:    rdata = 32'(mask);
                default: rdata = '0;
            endcase
        end
`endif
    end

endmodule

// File: tb/tb_pwm_multi_apb.sv
// tb_pwm_multi_apb: randomized APB traffic against a behavioural PWM model.
// The model tracks each channel as a phase within its period and checks
// PRDATA/PSLVERR every cycle plus pwm_out/irq after every clock edge.
module tb_pwm_multi_apb;

    localparam int NUM_CH     = 4;
    localparam int CNT_W      = 16;
    localparam int DEF_PERIOD = 10;
    localparam int DEF_DUTY   = 3;
    localparam logic [31:0] VMASK = 32'h0000FFFF;

    logic              PCLK;
    logic              PRESET;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [31:0]       PADDR;
    logic [31:0]       PWDATA;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;
    logic [NUM_CH-1:0] pwm_out;
    logic              irq;

    int tests_run;
    int tests_failed;

    logic [31:0] m_cnt    [NUM_CH];
    logic [31:0] m_per_a  [NUM_CH];
    logic [31:0] m_duty_a [NUM_CH];
    logic [31:0] m_per_s  [NUM_CH];
    logic [31:0] m_duty_s [NUM_CH];
    logic [NUM_CH-1:0] m_en;
    logic [NUM_CH-1:0] m_inv;
    logic [NUM_CH-1:0] m_out;
    logic [NUM_CH-1:0] m_status;
    logic [NUM_CH-1:0] m_mask;
    logic              m_irq;

    pwm_multi_apb #(
        .NUM_CH     (NUM_CH),
        .CNT_W      (CNT_W),
        .DEF_PERIOD (DEF_PERIOD),
        .DEF_DUTY   (DEF_DUTY)
    ) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .pwm_out (pwm_out),
        .irq     (irq)
    );

    // Free-running 100 MHz clock
    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] mk_addr(input int ch, input int rg);
        logic [31:0] a;
        a       = '0;
        a[11:8] = ch[3:0];
        a[3:2]  = rg[1:0];
        return a;
    endfunction

    function automatic logic [31:0] exp_prdata(input logic sel, input logic [31:0] addr);
        int ch;
        int rg;
        ch = int'(addr[11:8]);
        rg = int'(addr[3:2]);
        if (!sel) return 32'h0;
        if (ch < NUM_CH) begin
            case (rg)
                0:       return m_duty_s[ch];
                1:       return m_per_s[ch];
                2:       return {30'b0, m_inv[ch], m_en[ch]};
                default: return m_cnt[ch];
            endcase
        end
`ifdef PWM_IRQ_EN
        if (ch == 15 && rg == 0) return 32'(m_status);
        if (ch == 15 && rg == 1) return 32'(m_mask);
`endif
        return 32'h0;
    endfunction

    // One model clock: each channel is a phase (cnt) inside its active period
    task automatic modelStep(input logic rst, input logic sel, input logic ena,
                             input logic wr, input logic [31:0] addr, input logic [31:0] data);
        int ch;
        int rg;
        logic [NUM_CH-1:0] wrapped;
        ch      = int'(addr[11:8]);
        rg      = int'(addr[3:2]);
        wrapped = '0;
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_cnt[c]    = 0;
                m_per_a[c]  = DEF_PERIOD;
                m_per_s[c]  = DEF_PERIOD;
                m_duty_a[c] = DEF_DUTY;
                m_duty_s[c] = DEF_DUTY;
            end
            m_en     = '1;
            m_inv    = '0;
            m_out    = '0;
            m_status = '0;
            m_mask   = '0;
            m_irq    = 1'b0;
            return;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            m_out[c] = (m_en[c] && (m_cnt[c] < m_duty_a[c])) ^ m_inv[c];
            if (!m_en[c]) begin
                m_cnt[c]    = 0;
                m_per_a[c]  = m_per_s[c];
                m_duty_a[c] = m_duty_s[c];
            end else if (m_per_a[c] < 2) begin
                m_cnt[c] = 0;
            end else begin
                m_cnt[c] = (m_cnt[c] + 1) % m_per_a[c];
                if (m_cnt[c] == 0) begin
                    wrapped[c]  = 1'b1;
                    m_per_a[c]  = m_per_s[c];
                    m_duty_a[c] = m_duty_s[c];
                end
            end
        end
        if (sel && ena && wr && ch < NUM_CH) begin
            if (rg == 0) m_duty_s[ch] = data & VMASK;
            if (rg == 1) m_per_s[ch]  = data & VMASK;
            if (rg == 2) begin
                m_en[ch]  = data[0];
                m_inv[ch] = data[1];
            end
        end
`ifdef PWM_IRQ_EN
        if (sel && ena && wr && ch == 15 && rg == 0) m_status = m_status & ~data[NUM_CH-1:0];
        if (sel && ena && wr && ch == 15 && rg == 1) m_mask = data[NUM_CH-1:0];
        m_status = m_status | wrapped;
        m_irq    = |(m_status & m_mask);
`else
        m_irq = 1'b0;
`endif
    endtask

    // Drive one cycle of bus inputs, check combinational and registered outputs
    task automatic applyStimulus(input logic rst, input logic sel, input logic ena,
                                 input logic wr, input logic [31:0] addr, input logic [31:0] data);
        int ch;
        logic exp_err;
        @(negedge PCLK);
        PRESET  = rst;
        PSEL    = sel;
        PENABLE = ena;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = data;
        #1;
        ch      = int'(addr[11:8]);
        exp_err = sel && ena && (ch >= NUM_CH) && (ch != 15);
        checkOutput("prdata", PRDATA, exp_prdata(sel, addr));
        checkOutput("pslverr", 32'(PSLVERR), 32'(exp_err));
        checkOutput("pready", 32'(PREADY), 32'h1);
        modelStep(rst, sel, ena, wr, addr, data);
        @(posedge PCLK);
        #1;
        checkOutput("pwm_out", 32'(pwm_out), 32'(m_out));
        checkOutput("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic apbWrite(input logic [31:0] addr, input logic [31:0] data);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, addr, data);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, addr, data);
    endtask

    task automatic apbRead(input logic [31:0] addr);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, addr, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, addr, 32'h0);
    endtask

    // Directed test-plan scenarios followed by randomized traffic
    initial begin
        int ones;
        int tries;
        int ch;
        int rg;
        logic [31:0] addr;
        logic [31:0] data;
        tests_run    = 0;
        tests_failed = 0;
        PRESET  = 1'b1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        modelStep(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge PCLK);
        #1;
        checkOutput("reset_pwm_out", 32'(pwm_out), 32'h0);
        checkOutput("reset_irq", 32'(irq), 32'h0);

        // Default 3-high / 7-low waveform straight out of reset
        ones = 0;
        for (int k = 0; k < 20; k++) begin
            idle(1);
            if (k == 0) checkOutput("first_high", 32'(pwm_out[0]), 32'h1);
            if (pwm_out[0]) ones++;
        end
        checkOutput("reset_pattern_ones", 32'(ones), 32'd6);

        for (int c = 0; c < NUM_CH; c++) begin
            for (int r = 0; r < 4; r++) apbRead(mk_addr(c, r));
        end
        for (int k = 0; k < 12; k++) apbRead(mk_addr(0, 3));

        // Mid-period duty change on ch1, then readback of the shadow
        apbWrite(mk_addr(1, 0), 32'd7);
        apbRead(mk_addr(1, 0));
        idle(25);

        // ch2 constant low, then constant high, then inverted
        apbWrite(mk_addr(2, 0), 32'd0);
        idle(12);
        apbWrite(mk_addr(2, 0), 32'd12);
        idle(12);
        apbWrite(mk_addr(2, 2), 32'd3);
        idle(12);
        apbWrite(mk_addr(2, 0), 32'd0);
        idle(12);

        // Disable ch0 while its counter reads 5, then re-enable
        tries = 0;
        while (m_cnt[0] != 4 && tries < 20) begin
            idle(1);
            tries++;
        end
        checkOutput("wait_cnt4", 32'(m_cnt[0] == 4), 32'h1);
        apbWrite(mk_addr(0, 2), 32'h0);
        apbRead(mk_addr(0, 3));
        idle(2);
        checkOutput("disabled_low", 32'(pwm_out[0]), 32'h0);
        apbWrite(mk_addr(0, 2), 32'h1);
        idle(12);

        // Out-of-range channel and the global page
        apbWrite(mk_addr(6, 0), 32'd1);
        apbWrite(mk_addr(6, 2), 32'd0);
        apbRead(mk_addr(6, 1));
        apbRead(mk_addr(15, 0));
        apbWrite(mk_addr(15, 1), 32'h2);
        idle(12);
        apbWrite(mk_addr(15, 0), 32'h2);
        idle(3);

        // Reset mid-period, colliding with a write, then readback of defaults
        apbWrite(mk_addr(3, 1), 32'd5);
        idle(4);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, mk_addr(3, 0), 32'd9);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("midreset_out", 32'(pwm_out), 32'h0);
        for (int r = 0; r < 4; r++) apbRead(mk_addr(3, r));
        idle(5);

        // Randomized traffic, including truncated wide values and resets
        for (int n = 0; n < 400; n++) begin
            rg = $urandom_range(0, 3);
            case ($urandom_range(0, 9))
                7:       ch = 6;
                8:       ch = 15;
                9:       ch = $urandom_range(4, 14);
                default: ch = $urandom_range(0, 3);
            endcase
            if (rg == 2) begin
                data = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3))
                                                   : {30'b0, 1'($urandom_range(0, 1)), 1'b1};
            end else if ($urandom_range(0, 15) == 0) begin
                data = $urandom;
            end else begin
                data = 32'($urandom_range(0, 24));
            end
            addr = mk_addr(ch, rg) | ($urandom & 32'hFFFFF0F3);
            if ($urandom_range(0, 49) == 0) begin
                applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, addr, data);
            end else if ($urandom_range(0, 1) == 1) begin
                apbWrite(addr, data);
            end else begin
                apbRead(addr);
            end
            idle($urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
